imem_loader: RTL

- Run-time instruction-memory loader for Simple_Single_CPU. Replaces the bench-only file preload with a hardware write path.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word addresses starting at 0.
- Holds the CPU in reset until a load completes successfully.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads instruction memory from a big-endian byte stream and holds
//            the CPU in reset until a complete load has been written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              abort_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [31:0]       r_word;
    logic              r_loaded;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;

    logic              w_accept;
    logic              w_len_ok;
    logic              w_last;
    logic [31:0]       w_word_next;

    assign w_accept    = byte_valid_i && (r_state == S_RECV);
    assign w_len_ok    = (len_i != '0) && (len_i <= c_DEPTH);
    assign w_last      = ({1'b0, r_word_cnt} == (r_len - 1'b1));
    assign w_word_next = {r_word[23:0], byte_i};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_word     <= '0;
            r_loaded   <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_len_ok) begin
                            r_len      <= len_i;
                            r_byte_cnt <= '0;
                            r_word_cnt <= '0;
                            r_word     <= '0;
                            r_loaded   <= 1'b0;
                            r_state    <= S_RECV;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    // Abort takes priority over a byte offered in the same cycle.
                    if (abort_i) begin
                        r_word     <= '0;
                        r_byte_cnt <= '0;
                        r_err      <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (w_accept) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr <= r_word_cnt;
                            r_mem_data <= w_word_next;
                            r_state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_byte_cnt <= '0;
                    r_word     <= '0;
                    if (abort_i) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_state    <= w_last ? S_DONE : S_RECV;
                    end
                end
                S_DONE: begin
                    r_loaded <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The write strobe is decoded from state; address/data registers hold between writes.
    assign byte_ready_o = (r_state == S_RECV);
    assign mem_we_o     = (r_state == S_WRITE);
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;
    assign cpu_rst_n_o  = r_loaded && (r_state == S_IDLE);

endmodule
`default_nettype wire
